// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Control FSM for the multicycle RV32I core. Sequences each instruction
// through fetch/decode/execute/memory/writeback over a shared ALU and memory,
// stretches memory states on mem_ready, and flags illegal instructions.

module multicycle_control_unit #(
   parameter bit ENABLE_BNE      = 1'b1,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Instr,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [2:0]  ALUControl,
   output logic [2:0]  ImmSrc,
   output logic        instr_done,
   output logic        illegal_instr,
   output logic [3:0]  state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR_TGT = 4'd11,
      S_JALR_PC  = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   state_t      state_r;
   state_t      state_next_s;
   logic        illegal_r;

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic        funct7b5_s;
   logic        instr_unused_s;
   logic        alu_f3_legal_s;
   logic        br_beq_s;
   logic        br_bne_s;

   logic        pc_write_s;
   logic        ir_write_s;
   logic        reg_write_s;
   logic        mem_write_s;
   logic        adr_src_s;
   logic [1:0]  alu_src_a_s;
   logic [1:0]  alu_src_b_s;
   logic [1:0]  result_src_s;
   logic [2:0]  alu_control_s;
   logic [2:0]  imm_src_s;
   logic        instr_done_s;

   // Immediate format implied by the opcode
   function automatic logic [2:0] imm_sel_f(input logic [6:0] op);
      logic [2:0] sel;
      case (op)
         OP_STORE:  sel = IMM_S;
         OP_BRANCH: sel = IMM_B;
         OP_JAL:    sel = IMM_J;
         OP_LUI:    sel = IMM_U;
         default:   sel = IMM_I;
      endcase
      return sel;
   endfunction

   // ALU operation for the supported R/I-type funct3 values
   function automatic logic [2:0] alu_op_f(input logic [2:0] f3, input logic sub);
      logic [2:0] op;
      case (f3)
         3'b000:  op = sub ? ALU_SUB : ALU_ADD;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         3'b010:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // funct3 values the ALU paths implement
   function automatic logic alu_f3_legal_f(input logic [2:0] f3);
      logic ok;
      case (f3)
         3'b000, 3'b110, 3'b111, 3'b010: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign opcode_s       = Instr[6:0];
   assign funct3_s       = Instr[14:12];
   assign funct7b5_s     = Instr[30];
   assign instr_unused_s = ^{Instr[31], Instr[29:15], Instr[11:7]};
   assign alu_f3_legal_s = alu_f3_legal_f(funct3_s);
   assign br_beq_s       = (funct3_s == 3'b000);
   assign br_bne_s       = ENABLE_BNE && (funct3_s == 3'b001);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Sticky illegal-instruction flag, set once TRAP is reached
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
      end else if (state_r == S_TRAP) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_FETCH: begin
            if (mem_ready) state_next_s = S_DECODE;
            else           state_next_s = S_FETCH;
         end
         S_DECODE: begin
            case (opcode_s)
               OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
               OP_RTYPE:          state_next_s = S_EXECR;
               OP_ITYPE:          state_next_s = S_EXECI;
               OP_BRANCH:         state_next_s = S_BRANCH;
               OP_JAL:            state_next_s = S_JAL;
               OP_JALR:           state_next_s = S_JALR_TGT;
               OP_LUI:            state_next_s = S_LUI;
               default:           state_next_s = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            // opcode bit 5 separates stores (0100011) from loads (0000011)
            if (opcode_s[5]) state_next_s = S_MEMWRITE;
            else             state_next_s = S_MEMREAD;
         end
         S_MEMREAD: begin
            if (mem_ready) state_next_s = S_MEMWB;
            else           state_next_s = S_MEMREAD;
         end
         S_MEMWB: state_next_s = S_FETCH;
         S_MEMWRITE: begin
            if (mem_ready) state_next_s = S_FETCH;
            else           state_next_s = S_MEMWRITE;
         end
         S_EXECR, S_EXECI: begin
            if (alu_f3_legal_s) state_next_s = S_ALUWB;
            else                state_next_s = S_TRAP;
         end
         S_ALUWB: state_next_s = S_FETCH;
         S_BRANCH: begin
            if (br_beq_s || br_bne_s) state_next_s = S_FETCH;
            else                      state_next_s = S_TRAP;
         end
         S_JAL:      state_next_s = S_ALUWB;
         S_JALR_TGT: state_next_s = S_JALR_PC;
         S_JALR_PC:  state_next_s = S_ALUWB;
         S_LUI:      state_next_s = S_ALUWB;
         S_TRAP: begin
            if (TRAP_ON_ILLEGAL) state_next_s = S_TRAP;
            else                 state_next_s = S_FETCH;
         end
         default: state_next_s = S_FETCH;
      endcase
   end

   // Per-state datapath controls
   always_comb begin
      pc_write_s    = 1'b0;
      ir_write_s    = 1'b0;
      reg_write_s   = 1'b0;
      mem_write_s   = 1'b0;
      adr_src_s     = 1'b0;
      alu_src_a_s   = 2'b00;
      alu_src_b_s   = 2'b00;
      result_src_s  = 2'b00;
      alu_control_s = ALU_ADD;
      imm_src_s     = IMM_I;
      instr_done_s  = 1'b0;
      case (state_r)
         S_FETCH: begin
            alu_src_b_s  = 2'b10;
            result_src_s = 2'b10;
            ir_write_s   = mem_ready;
            pc_write_s   = mem_ready;
         end
         S_DECODE: begin
            // OldPC + Imm: branch/JAL target lands in ALUOut
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b01;
            imm_src_s   = imm_sel_f(opcode_s);
         end
         S_MEMADR: begin
            // Immediate format kept live so stores use the S-type offset
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
            imm_src_s   = imm_sel_f(opcode_s);
         end
         S_MEMREAD: begin
            adr_src_s = 1'b1;
         end
         S_MEMWB: begin
            result_src_s = 2'b01;
            reg_write_s  = 1'b1;
            instr_done_s = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src_s    = 1'b1;
            mem_write_s  = 1'b1;
            instr_done_s = mem_ready;
         end
         S_EXECR: begin
            alu_src_a_s   = 2'b10;
            alu_control_s = alu_op_f(funct3_s, funct7b5_s);
         end
         S_EXECI: begin
            alu_src_a_s   = 2'b10;
            alu_src_b_s   = 2'b01;
            imm_src_s     = imm_sel_f(opcode_s);
            alu_control_s = alu_op_f(funct3_s, 1'b0);
         end
         S_ALUWB: begin
            reg_write_s  = 1'b1;
            instr_done_s = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_s   = 2'b10;
            alu_control_s = ALU_SUB;
            if (br_beq_s) begin
               pc_write_s   = Zero;
               instr_done_s = 1'b1;
            end else if (br_bne_s) begin
               pc_write_s   = ~Zero;
               instr_done_s = 1'b1;
            end else begin
               pc_write_s   = 1'b0;
               instr_done_s = 1'b0;
            end
         end
         S_JAL, S_JALR_PC: begin
            // OldPC + 4 computed while PC takes the target held in ALUOut
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b10;
            pc_write_s  = 1'b1;
         end
         S_JALR_TGT: begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
            imm_src_s   = imm_sel_f(opcode_s);
         end
         S_LUI: begin
            imm_src_s     = IMM_U;
            alu_src_b_s   = 2'b01;
            alu_control_s = ALU_PASSB;
         end
         S_TRAP: begin
            instr_done_s = ~TRAP_ON_ILLEGAL;
         end
         default: begin
            pc_write_s = 1'b0;
         end
      endcase
   end

   // Enables are forced low while reset is held, independent of the clock
   assign PCWrite       = rst_n & pc_write_s;
   assign IRWrite       = rst_n & ir_write_s;
   assign RegWrite      = rst_n & reg_write_s;
   assign MemWrite      = rst_n & mem_write_s;
   assign instr_done    = rst_n & instr_done_s;
   assign AdrSrc        = adr_src_s;
   assign ALUSrcA       = alu_src_a_s;
   assign ALUSrcB       = alu_src_b_s;
   assign ResultSrc     = result_src_s;
   assign ALUControl    = alu_control_s;
   assign ImmSrc        = imm_src_s;
   assign illegal_instr = illegal_r | (state_r == S_TRAP);
   assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit: default build plus a
// build without BNE and a build that retires illegal instructions as NOPs.

module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Instr;
   logic        Zero;
   logic        mem_ready;

   logic       pcw, irw, rgw, mw, adr, done, ill;
   logic [1:0] sa, sb, rs;
   logic [2:0] aluc, imm;
   logic [3:0] st;

   logic       nb_pcw, nb_irw, nb_rgw, nb_mw, nb_adr, nb_done, nb_ill;
   logic [1:0] nb_sa, nb_sb, nb_rs;
   logic [2:0] nb_aluc, nb_imm;
   logic [3:0] nb_st;

   logic       nt_pcw, nt_irw, nt_rgw, nt_mw, nt_adr, nt_done, nt_ill;
   logic [1:0] nt_sa, nt_sb, nt_rs;
   logic [2:0] nt_aluc, nt_imm;
   logic [3:0] nt_st;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(pcw), .IRWrite(irw), .RegWrite(rgw), .MemWrite(mw), .AdrSrc(adr),
      .ALUSrcA(sa), .ALUSrcB(sb), .ResultSrc(rs), .ALUControl(aluc), .ImmSrc(imm),
      .instr_done(done), .illegal_instr(ill), .state_o(st)
   );

   multicycle_control_unit #(.ENABLE_BNE(1'b0), .TRAP_ON_ILLEGAL(1'b1)) dut_nb (
      .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(nb_pcw), .IRWrite(nb_irw), .RegWrite(nb_rgw), .MemWrite(nb_mw), .AdrSrc(nb_adr),
      .ALUSrcA(nb_sa), .ALUSrcB(nb_sb), .ResultSrc(nb_rs), .ALUControl(nb_aluc), .ImmSrc(nb_imm),
      .instr_done(nb_done), .illegal_instr(nb_ill), .state_o(nb_st)
   );

   multicycle_control_unit #(.ENABLE_BNE(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
      .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(nt_pcw), .IRWrite(nt_irw), .RegWrite(nt_rgw), .MemWrite(nt_mw), .AdrSrc(nt_adr),
      .ALUSrcA(nt_sa), .ALUSrcB(nt_sb), .ResultSrc(nt_rs), .ALUControl(nt_aluc), .ImmSrc(nt_imm),
      .instr_done(nt_done), .illegal_instr(nt_ill), .state_o(nt_st)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Advance one clock and sample just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two edges, check the reset state, then release
   task automatic do_reset();
      rst_n     = 1'b0;
      Zero      = 1'b0;
      mem_ready = 1'b1;
      Instr     = 32'h0000_0013;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_state", 32'(st), 32'd0);
      check_eq("rst_irwrite", 32'(irw), 32'd0);
      check_eq("rst_pcwrite", 32'(pcw), 32'd0);
      check_eq("rst_illegal", 32'(ill), 32'd0);
      check_eq("rst_nt_illegal", 32'(nt_ill), 32'd0);
      rst_n = 1'b1;
   endtask

   // Four-state instruction ending in ALUWB: FETCH, DECODE, exec, ALUWB
   task automatic run_alu(input string tag, input logic [31:0] ins,
                          input logic [3:0] exec_st, input logic [2:0] exp_alu);
      Instr = ins;
      #1;
      check_eq({tag, "_fetch"}, 32'(st), 32'd0);
      check_eq({tag, "_fetch_irw"}, 32'(irw), 32'd1);
      step();
      check_eq({tag, "_decode"}, 32'(st), 32'd1);
      check_eq({tag, "_decode_done"}, 32'(done), 32'd0);
      step();
      check_eq({tag, "_exec"}, 32'(st), 32'(exec_st));
      check_eq({tag, "_aluctl"}, 32'(aluc), 32'(exp_alu));
      step();
      check_eq({tag, "_wb"}, 32'(st), 32'd8);
      check_eq({tag, "_wb_regwrite"}, 32'(rgw), 32'd1);
      check_eq({tag, "_wb_done"}, 32'(done), 32'd1);
      step();
      check_eq({tag, "_next_fetch"}, 32'(st), 32'd0);
      check_eq({tag, "_next_done"}, 32'(done), 32'd0);
   endtask

   logic [3:0] jalr_st  [5] = '{4'd0, 4'd1, 4'd11, 4'd12, 4'd8};
   logic       jalr_pcw [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      do_reset();

      // R-type, I-type (bit 30 ignored), LUI, JAL
      run_alu("add",  32'h0020_81B3, 4'd6,  3'b000);
      run_alu("sub",  32'h4020_81B3, 4'd6,  3'b001);
      run_alu("and",  32'h0020_F1B3, 4'd6,  3'b010);
      run_alu("ori",  32'h0010_E193, 4'd7,  3'b011);
      run_alu("addi30", 32'h4000_8193, 4'd7, 3'b000);
      run_alu("slti", 32'h0010_A193, 4'd7,  3'b101);
      run_alu("lui",  32'h0000_11B7, 4'd13, 3'b100);
      run_alu("jal",  32'h0000_006F, 4'd10, 3'b000);

      // Load with mem_ready low for two MEMREAD cycles: 7 cycles total
      Instr = 32'h0000_A183;
      #1;
      check_eq("lw_fetch", 32'(st), 32'd0);
      step();
      check_eq("lw_decode", 32'(st), 32'd1);
      step();
      check_eq("lw_memadr", 32'(st), 32'd2);
      check_eq("lw_memadr_srca", 32'(sa), 32'd2);
      mem_ready = 1'b0;
      step();
      check_eq("lw_memread1", 32'(st), 32'd3);
      check_eq("lw_memread_adr", 32'(adr), 32'd1);
      step();
      check_eq("lw_memread2", 32'(st), 32'd3);
      step();
      check_eq("lw_memread3", 32'(st), 32'd3);
      check_eq("lw_memread3_done", 32'(done), 32'd0);
      mem_ready = 1'b1;
      step();
      check_eq("lw_memwb", 32'(st), 32'd4);
      check_eq("lw_memwb_result", 32'(rs), 32'd1);
      check_eq("lw_memwb_regwrite", 32'(rgw), 32'd1);
      check_eq("lw_memwb_done", 32'(done), 32'd1);
      step();
      check_eq("lw_next_fetch", 32'(st), 32'd0);

      // Store with mem_ready high: 4 cycles
      Instr = 32'h0030_A023;
      step(); step(); step();
      check_eq("sw_memwrite", 32'(st), 32'd5);
      check_eq("sw_memwrite_we", 32'(mw), 32'd1);
      check_eq("sw_memwrite_done", 32'(done), 32'd1);
      step();
      check_eq("sw_next_fetch", 32'(st), 32'd0);

      // BEQ taken, BNE with Zero=1 (not taken), BNE with Zero=0 (taken)
      Zero  = 1'b1;
      Instr = 32'h0020_8463;
      step(); step();
      check_eq("beq_branch", 32'(st), 32'd9);
      check_eq("beq_pcwrite", 32'(pcw), 32'd1);
      check_eq("beq_aluctl", 32'(aluc), 32'd1);
      check_eq("beq_done", 32'(done), 32'd1);
      step();
      Instr = 32'h0020_9463;
      step(); step();
      check_eq("bne_z1_pcwrite", 32'(pcw), 32'd0);
      check_eq("bne_z1_done", 32'(done), 32'd1);
      check_eq("nobne_branch", 32'(nb_st), 32'd9);
      check_eq("nobne_done", 32'(nb_done), 32'd0);
      step();
      check_eq("bne_next_fetch", 32'(st), 32'd0);
      check_eq("nobne_trap", 32'(nb_st), 32'd14);
      check_eq("nobne_illegal", 32'(nb_ill), 32'd1);
      Zero = 1'b0;
      step(); step();
      check_eq("bne_z0_pcwrite", 32'(pcw), 32'd1);
      step();

      // JALR: states 0,1,11,12,8 with PCWrite only in FETCH and JALR_PC
      Instr = 32'h0000_80E7;
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         check_eq("jalr_state", 32'(st), 32'(jalr_st[i]));
         check_eq("jalr_pcwrite", 32'(pcw), 32'(jalr_pcw[i]));
      end
      step();

      // Unsupported R-type funct3 (SLL) traps from EXECR
      Instr = 32'h0020_91B3;
      step(); step();
      check_eq("sll_execr", 32'(st), 32'd6);
      step();
      check_eq("sll_trap", 32'(st), 32'd14);

      // Illegal opcode: parked in TRAP vs. retired as NOP
      do_reset();
      Instr = 32'h0000_007F;
      step(); step();
      check_eq("ill_trap", 32'(st), 32'd14);
      check_eq("ill_flag", 32'(ill), 32'd1);
      check_eq("ill_done", 32'(done), 32'd0);
      check_eq("nop_trap", 32'(nt_st), 32'd14);
      check_eq("nop_done", 32'(nt_done), 32'd1);
      step();
      check_eq("nop_fetch", 32'(nt_st), 32'd0);
      check_eq("nop_sticky", 32'(nt_ill), 32'd1);
      check_eq("nop_done_end", 32'(nt_done), 32'd0);
      repeat (3) step();
      check_eq("ill_held", 32'(st), 32'd14);
      check_eq("ill_held_flag", 32'(ill), 32'd1);
      check_eq("ill_held_done", 32'(done), 32'd0);

      // Reset asserted mid-store while memory is stalled
      do_reset();
      Instr = 32'h0030_A023;
      step(); step();
      mem_ready = 1'b0;
      step();
      check_eq("rst_sw_memwrite", 32'(st), 32'd5);
      check_eq("rst_sw_we", 32'(mw), 32'd1);
      check_eq("rst_sw_nodone", 32'(done), 32'd0);
      step();
      check_eq("rst_sw_held", 32'(st), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_sw_we_drop", 32'(mw), 32'd0);
      check_eq("rst_sw_state", 32'(st), 32'd0);
      step();
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      #1;
      check_eq("rst_sw_restart", 32'(st), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
